serial_crc_checker: RTL and testbench

Receive-side counterpart of the team's serial CRC generator: consumes a serial frame (payload bits followed by the appended CRC, both MSB-first), recomputes the CRC over the payload and compares it with the received CRC. It sits behind the serial deserializer/link receiver and reports one pass/fail result per frame. The CRC algorithm matches the generator exactly:
- Modes: CRC8, CRC16 or CRC32.
- Init value: all-ones.
- Feedback: `crc[W-1] ^ bit`.
- Update: shift left; XOR `polynomial` when feedback is 1; mask to W bits.
- No reflection, no final XOR.

---
 rtl/serial_crc_pkg.sv | 34 +++
 rtl/serial_crc_step.sv | 24 ++
 rtl/serial_crc_checker.sv | 193 +++++++++++++++++++
 tb/tb_serial_crc_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_crc_pkg.sv
// Shared definitions for the serial CRC generator/checker pair.
// Provides the CRC mode encodings, per-mode width and mask helpers and the
// checker FSM state type.
package serial_crc_pkg;

  localparam logic [1:0] CRC_MODE_8  = 2'b00;
  localparam logic [1:0] CRC_MODE_16 = 2'b01;
  localparam logic [1:0] CRC_MODE_32 = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StCheck
  } state_e;

  // CRC width in bits for a mode; the unused encoding 2'b11 falls back to CRC8.
  function automatic logic [5:0] crc_width(input logic [1:0] mode);
    case (mode)
      CRC_MODE_16: crc_width = 6'd16;
      CRC_MODE_32: crc_width = 6'd32;
      default:     crc_width = 6'd8;
    endcase
  endfunction

  // All-ones mask of the mode's width; doubles as the LFSR init value.
  function automatic logic [31:0] crc_mask(input logic [1:0] mode);
    case (mode)
      CRC_MODE_16: crc_mask = 32'h0000_FFFF;
      CRC_MODE_32: crc_mask = 32'hFFFF_FFFF;
      default:     crc_mask = 32'h0000_00FF;
    endcase
  endfunction

endpackage

// File: rtl/serial_crc_step.sv
// One-bit CRC LFSR update, shared by the serial CRC generator and checker.
// Ports:
//   crc_i   current CRC value (bits above the width are ignored)
//   bit_i   serial input bit
//   poly_i  generator polynomial
//   mask_i  all-ones mask of the CRC width
//   crc_o   next CRC value, masked to the width
module serial_crc_step (
  input  logic [31:0] crc_i,
  input  logic        bit_i,
  input  logic [31:0] poly_i,
  input  logic [31:0] mask_i,
  output logic [31:0] crc_o
);

  logic [31:0] top_bit;
  logic        fb;

  // The mask is contiguous from bit 0, so its highest set bit is the CRC MSB.
  assign top_bit = mask_i & ~(mask_i >> 1);
  assign fb      = (|(crc_i & top_bit)) ^ bit_i;
  assign crc_o   = ((crc_i << 1) ^ (fb ? poly_i : 32'h0)) & mask_i;

endmodule

// File: rtl/serial_crc_checker.sv
// Serial CRC checker: takes payload bits followed by the appended CRC (both
// MSB-first), recomputes the CRC over the payload and compares it with the
// received one, reporting one pass/fail result per frame.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   data_in, data_valid    serial bit and its qualifier
//   sof                    start of frame (with data_valid), marks payload bit 0
//   payload_len            payload length in bits, sampled at sof
//   crc_mode, polynomial   CRC configuration, sampled at sof
//   busy                   frame in progress
//   done, crc_ok, crc_err  one-cycle result pulse and verdict
//   restart                one-cycle pulse: sof arrived mid-frame
//   crc_calc, crc_rx       computed and received CRC, held until next done
module serial_crc_checker
  import serial_crc_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             sof,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [1:0]       crc_mode,
  input  logic [31:0]      polynomial,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             restart,
  output logic [31:0]      crc_calc,
  output logic [31:0]      crc_rx
);

  state_e           state_q, state_d;
  logic [5:0]       width_q, width_d;
  logic [31:0]      mask_q, mask_d;
  logic [31:0]      poly_q, poly_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [5:0]       crc_cnt_q, crc_cnt_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      rx_sh_q, rx_sh_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             restart_q, restart_d;
  logic [31:0]      calc_q, calc_d;
  logic [31:0]      rx_q, rx_d;

  logic        start;
  logic [31:0] mask_new;
  logic [31:0] poly_new;
  logic [31:0] step_crc, step_poly, step_mask, step_out;
  logic [31:0] rx_next;
  logic [LEN_W-1:0] cnt_inc;
  logic [5:0]  crc_cnt_inc;

  assign start    = data_valid & sof;
  assign mask_new = crc_mask(crc_mode);
  assign poly_new = polynomial & mask_new;

  // On sof the LFSR is seeded and stepped with bit 0 in the same cycle, so the
  // step unit sees the freshly sampled configuration instead of the registers.
  assign step_crc  = start ? mask_new : lfsr_q;
  assign step_poly = start ? poly_new : poly_q;
  assign step_mask = start ? mask_new : mask_q;

  serial_crc_step u_step (
    .crc_i  (step_crc),
    .bit_i  (data_in),
    .poly_i (step_poly),
    .mask_i (step_mask),
    .crc_o  (step_out)
  );

  assign rx_next     = {rx_sh_q[30:0], data_in};
  assign cnt_inc     = cnt_q + LEN_W'(1);
  assign crc_cnt_inc = crc_cnt_q + 6'd1;

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    mask_d    = mask_q;
    poly_d    = poly_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    crc_cnt_d = crc_cnt_q;
    lfsr_d    = lfsr_q;
    rx_sh_d   = rx_sh_q;
    done_d    = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    restart_d = 1'b0;
    calc_d    = calc_q;
    rx_d      = rx_q;

    if (start) begin
      // A sof mid-frame drops the old frame silently and starts the new one.
      restart_d = (state_q != StIdle);
      width_d   = crc_width(crc_mode);
      mask_d    = mask_new;
      poly_d    = poly_new;
      len_d     = payload_len;
      if (payload_len == '0) begin
        // Empty payload: the sof bit is already the first CRC bit.
        lfsr_d    = mask_new;
        rx_sh_d   = {31'h0, data_in};
        crc_cnt_d = 6'd1;
        state_d   = StCheck;
      end else begin
        lfsr_d    = step_out;
        cnt_d     = LEN_W'(1);
        rx_sh_d   = 32'h0;
        crc_cnt_d = 6'd0;
        state_d   = (payload_len == LEN_W'(1)) ? StCheck : StPayload;
      end
    end else if (data_valid) begin
      unique case (state_q)
        StIdle: begin
        end
        StPayload: begin
          lfsr_d = step_out;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = StCheck;
          end
        end
        StCheck: begin
          rx_sh_d   = rx_next;
          crc_cnt_d = crc_cnt_inc;
          if (crc_cnt_inc == width_q) begin
            done_d  = 1'b1;
            calc_d  = lfsr_q;
            rx_d    = rx_next & mask_q;
            ok_d    = ((rx_next & mask_q) == lfsr_q);
            err_d   = ((rx_next & mask_q) != lfsr_q);
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      width_q   <= 6'd8;
      mask_q    <= 32'h0;
      poly_q    <= 32'h0;
      len_q     <= '0;
      cnt_q     <= '0;
      crc_cnt_q <= 6'd0;
      lfsr_q    <= 32'h0;
      rx_sh_q   <= 32'h0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      restart_q <= 1'b0;
      calc_q    <= 32'h0;
      rx_q      <= 32'h0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      mask_q    <= mask_d;
      poly_q    <= poly_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      crc_cnt_q <= crc_cnt_d;
      lfsr_q    <= lfsr_d;
      rx_sh_q   <= rx_sh_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      restart_q <= restart_d;
      calc_q    <= calc_d;
      rx_q      <= rx_d;
    end
  end

  // The FSM is already back in idle during the done cycle, yet the frame
  // still counts as in progress there.
  assign busy     = (state_q != StIdle) | done_q;
  assign done     = done_q;
  assign crc_ok   = ok_q;
  assign crc_err  = err_q;
  assign restart  = restart_q;
  assign crc_calc = calc_q;
  assign crc_rx   = rx_q;

endmodule

// File: tb/tb_serial_crc_checker.sv
module tb_serial_crc_checker;

  localparam int LEN_W = 16;

  logic             clk;
  logic             rst_n;
  logic             data_in;
  logic             data_valid;
  logic             sof;
  logic [LEN_W-1:0] payload_len;
  logic [1:0]       crc_mode;
  logic [31:0]      polynomial;
  logic             busy, done, crc_ok, crc_err, restart;
  logic [31:0]      crc_calc, crc_rx;

  int n_checks = 0;
  int n_errors = 0;

  int done_cnt = 0;
  int ok_cnt = 0;
  int restart_cnt = 0;
  int proto_bad = 0;
  int busy_drop = 0;
  logic        last_ok, last_err;
  logic [31:0] last_calc, last_rx;

  serial_crc_checker #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .sof         (sof),
    .payload_len (payload_len),
    .crc_mode    (crc_mode),
    .polynomial  (polynomial),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .restart     (restart),
    .crc_calc    (crc_calc),
    .crc_rx      (crc_rx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output monitor, sampled away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (crc_ok) ok_cnt++;
        last_ok   = crc_ok;
        last_err  = crc_err;
        last_calc = crc_calc;
        last_rx   = crc_rx;
      end
      if (restart) restart_cnt++;
      if (done ? (crc_ok == crc_err) : (crc_ok | crc_err)) proto_bad++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] mode);
    if (mode == 2'b01) return 16;
    if (mode == 2'b10) return 32;
    return 8;
  endfunction

  // Reference CRC: all-ones init, MSB-first, no reflection, no final XOR.
  function automatic logic [31:0] model_crc(input logic [63:0] payload, input int plen,
                                            input int w, input logic [31:0] poly);
    logic [63:0] crc;
    logic [63:0] mask;
    logic        fb;
    mask = (64'd1 << w) - 64'd1;
    crc  = mask;
    for (int i = plen - 1; i >= 0; i--) begin
      fb  = crc[w-1] ^ payload[i];
      crc = (crc << 1) ^ (fb ? ({32'h0, poly} & mask) : 64'h0);
      crc = crc & mask;
    end
    return crc[31:0];
  endfunction

  // Drives a frame bit by bit; limit >= 0 truncates the stream after that many bits.
  task automatic send_frame(input logic [63:0] payload, input int plen, input logic [1:0] mode,
                            input logic [31:0] poly, input logic [31:0] crc, input int gap_pct,
                            input int limit);
    int w;
    int total;
    bit started;
    logic b;
    w       = width_of(mode);
    total   = plen + w;
    started = 1'b0;
    if (limit >= 0 && limit < total) total = limit;
    for (int i = 0; i < total; i++) begin
      if (i < plen) b = payload[plen-1-i];
      else          b = crc[w-1-(i-plen)];
      while (started && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        if (!busy) busy_drop++;
        data_valid = 1'b0;
        sof        = 1'b0;
        data_in    = 1'($urandom);
      end
      @(negedge clk);
      if (started && !busy) busy_drop++;
      data_in     = b;
      data_valid  = 1'b1;
      sof         = (i == 0);
      payload_len = LEN_W'(plen);
      crc_mode    = mode;
      polynomial  = poly;
      started     = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_valid = 1'b0;
      sof        = 1'b0;
    end
  endtask

  task automatic verify_frame(input string tag, input int d0, input logic [31:0] exp_calc,
                              input logic [31:0] exp_rx);
    check_eq({tag, ".done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, ".ok"}, {31'h0, last_ok}, {31'h0, exp_calc == exp_rx});
    check_eq({tag, ".err"}, {31'h0, last_err}, {31'h0, exp_calc != exp_rx});
    check_eq({tag, ".calc"}, last_calc, exp_calc);
    check_eq({tag, ".rx"}, last_rx, exp_rx);
  endtask

  initial begin
    int d0, r0, o0, b0;
    logic [63:0] pl;
    logic [31:0] c, c2;
    int plen, w;
    logic [1:0] mode;
    logic [31:0] poly;

    rst_n       = 1'b0;
    data_in     = 1'b0;
    data_valid  = 1'b0;
    sof         = 1'b0;
    payload_len = '0;
    crc_mode    = 2'b00;
    polynomial  = 32'h0;
    repeat (3) @(negedge clk);

    check_eq("rst.busy", {31'h0, busy}, 32'h0);
    check_eq("rst.done", {31'h0, done}, 32'h0);
    check_eq("rst.ok", {31'h0, crc_ok}, 32'h0);
    check_eq("rst.err", {31'h0, crc_err}, 32'h0);
    check_eq("rst.restart", {31'h0, restart}, 32'h0);
    check_eq("rst.calc", crc_calc, 32'h0);
    check_eq("rst.rx", crc_rx, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // CRC8 over a zero byte, correct and corrupted CRC.
    check_eq("model.crc8_zero", model_crc(64'h0, 8, 8, 32'h07), 32'hF3);
    d0 = done_cnt;
    send_frame(64'h0, 8, 2'b00, 32'h07, 32'hF3, 0, -1);
    idle(3);
    verify_frame("crc8_ok", d0, 32'hF3, 32'hF3);
    d0 = done_cnt;
    send_frame(64'h0, 8, 2'b00, 32'h07, 32'hF2, 0, -1);
    idle(3);
    verify_frame("crc8_bad", d0, 32'hF3, 32'hF2);

    // CRC32, 64-bit random payload, heavy stalls.
    pl = {$urandom, $urandom};
    c  = model_crc(pl, 64, 32, 32'h04C11DB7);
    d0 = done_cnt;
    b0 = busy_drop;
    send_frame(pl, 64, 2'b10, 32'h04C11DB7, c, 50, -1);
    idle(4);
    verify_frame("crc32", d0, c, c);
    check_eq("crc32.busy_drop", 32'(busy_drop - b0), 32'h0);

    // Back-to-back CRC16 frames, second sof lands in the done cycle.
    d0 = done_cnt;
    r0 = restart_cnt;
    o0 = ok_cnt;
    pl = {32'h0, $urandom};
    c  = model_crc(pl, 24, 16, 32'h8005);
    send_frame(pl, 24, 2'b01, 32'h8005, c, 0, -1);
    pl = {32'h0, $urandom};
    c2 = model_crc(pl, 20, 16, 32'h8005);
    send_frame(pl, 20, 2'b01, 32'h8005, c2, 0, -1);
    idle(3);
    check_eq("b2b.done_cnt", 32'(done_cnt - d0), 32'd2);
    check_eq("b2b.ok_cnt", 32'(ok_cnt - o0), 32'd2);
    check_eq("b2b.restart", 32'(restart_cnt - r0), 32'd0);
    check_eq("b2b.calc", last_calc, c2);

    // sof at payload bit 5 of a CRC8 frame.
    d0 = done_cnt;
    r0 = restart_cnt;
    pl = {48'h0, 16'($urandom)};
    send_frame(pl, 16, 2'b00, 32'h07, 32'h0, 0, 5);
    pl = {48'h0, 16'($urandom)};
    c  = model_crc(pl, 12, 8, 32'h31);
    send_frame(pl, 12, 2'b00, 32'h31, c, 0, -1);
    idle(3);
    check_eq("restart.cnt", 32'(restart_cnt - r0), 32'd1);
    verify_frame("restart", d0, c, c);

    // Reset while in CHECK.
    d0 = done_cnt;
    pl = {54'h0, 10'($urandom)};
    c  = model_crc(pl, 10, 16, 32'h1021);
    send_frame(pl, 10, 2'b01, 32'h1021, c, 0, 15);
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    sof        = 1'b0;
    #1;
    check_eq("midrst.busy", {31'h0, busy}, 32'h0);
    check_eq("midrst.done", {31'h0, done}, 32'h0);
    check_eq("midrst.calc", crc_calc, 32'h0);
    check_eq("midrst.rx", crc_rx, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_eq("midrst.no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    send_frame(pl, 10, 2'b01, 32'h1021, c, 0, -1);
    idle(3);
    verify_frame("postrst", d0, c, c);

    // Random frames including empty and single-bit payloads.
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      plen = 0;
      else if (k == 1) plen = 1;
      else             plen = $urandom_range(2, 64);
      mode = 2'($urandom);
      w    = width_of(mode);
      poly = $urandom | 32'h1;
      pl   = {$urandom, $urandom};
      c    = model_crc(pl, plen, w, poly);
      c2   = c;
      if (k % 2 == 1) c2 = c ^ (32'h1 << $urandom_range(0, w - 1));
      d0 = done_cnt;
      send_frame(pl, plen, mode, poly, c2, 30, -1);
      idle(3);
      verify_frame($sformatf("rnd%0d", k), d0, c, c2);
    end

    check_eq("protocol.ok_err", 32'(proto_bad), 32'h0);
    check_eq("busy.held", 32'(busy_drop), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
